sr_latch_driver: RTL

Clocked front end that turns two raw, bouncy pushbutton inputs into clean, mutually exclusive set/reset pulses for the NOR-based SR latch stage. The block synchronises and debounces both buttons, then detects presses and issues fixed-width S or R pulses. A guard cycle follows every pulse, and the latch never sees S=R=1. It sits directly upstream of the latch: its S/R outputs drive the latch's S and R inputs.

---
 rtl/sr_latch_driver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sr_latch_driver.sv
// Debounced pushbutton front end producing mutually exclusive, fixed-width S/R pulses for a NOR SR latch.
// Define SR_DRV_RESET_PRIORITY_EN to let reset win a simultaneous press (default: both presses discarded).
module sr_latch_driver #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_WIDTH     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PCW = $clog2(PULSE_WIDTH + 1);
  localparam logic [DW-1:0]  DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SET_PULSE, RST_PULSE, GUARD} state_t;

  // Bit 0 carries the set button, bit 1 the reset button.
  logic [1:0]    btn;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_d1;
  logic [DW-1:0] db_cnt [2];
  logic          set_req;
  logic          rst_req;

  state_t         state;
  logic [PCW-1:0] pulse_cnt;

  assign btn = {reset_btn, set_btn};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      deb    <= '0;
      deb_d1 <= '0;
      // NOTE: the counter array is small and must start at zero, so it is reset element by element.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1  <= btn;
      sync2  <= sync1;
      deb_d1 <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Only press edges matter; release edges never request anything.
  assign set_req = deb[0] & ~deb_d1[0];
  assign rst_req = deb[1] & ~deb_d1[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pulse_cnt <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
      busy      <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      conflict <= 1'b0;
      case (state)
        IDLE: begin
          pulse_cnt <= '0;
          if (set_req && rst_req) begin
`ifdef SR_DRV_RESET_PRIORITY_EN
            state    <= RST_PULSE;
            R        <= 1'b1;
            busy     <= 1'b1;
            conflict <= 1'b1;
`else
            conflict <= 1'b1;
`endif
          end else if (set_req) begin
            state <= SET_PULSE;
            S     <= 1'b1;
            busy  <= 1'b1;
          end else if (rst_req) begin
            state <= RST_PULSE;
            R     <= 1'b1;
            busy  <= 1'b1;
          end
        end
        SET_PULSE, RST_PULSE: begin
          if (pulse_cnt == PULSE_LAST) begin
            state     <= GUARD;
            S         <= 1'b0;
            R         <= 1'b0;
            pulse_cnt <= '0;
          end else begin
            pulse_cnt <= pulse_cnt + PCW'(1);
          end
        end
        GUARD: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          S     <= 1'b0;
          R     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
